// File: rtl/bublesort_pkg.sv
// Shared definitions for the bublesort host driver: FSM state encoding and index sizing.
package bublesort_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    function automatic int unsigned clog2_min1(input int unsigned k);
        return (k < 2) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/bublesort_stream_drv_if.sv
// Host stream, control/status and sorter-side signals of the bublesort driver.
interface bublesort_stream_drv_if #(
    parameter int unsigned N_BITS    = 8,
    parameter int unsigned K_NUMBERS = 49
);
    logic                        s_valid_i;
    logic [N_BITS-1:0]           s_data_i;
    logic                        s_ready_o;
    logic                        m_valid_o;
    logic [N_BITS-1:0]           m_data_o;
    logic                        m_last_o;
    logic                        m_ready_i;
    logic                        abort_i;
    logic                        busy_o;
    logic                        tmo_err_o;
    logic [K_NUMBERS-1:0]        load_o;
    logic [K_NUMBERS*N_BITS-1:0] writedata_o;
    logic [K_NUMBERS*N_BITS-1:0] readdata_i;
    logic                        start_o;
    logic                        abort_o;
    logic                        done_i;

    // Driver side
    modport slave (
        input  s_valid_i, s_data_i, m_ready_i, abort_i, readdata_i, done_i,
        output s_ready_o, m_valid_o, m_data_o, m_last_o, busy_o, tmo_err_o,
               load_o, writedata_o, start_o, abort_o
    );

    // Host / sorter side
    modport master (
        output s_valid_i, s_data_i, m_ready_i, abort_i, readdata_i, done_i,
        input  s_ready_o, m_valid_o, m_data_o, m_last_o, busy_o, tmo_err_o,
               load_o, writedata_o, start_o, abort_o
    );

endinterface

// File: rtl/bublesort_tmo_cnt.sv
// Saturating WAIT-state cycle counter with a terminal-count flag at TMO_CYC-1.
module bublesort_tmo_cnt
    import bublesort_pkg::*;
#(
    parameter int unsigned TMO_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int unsigned        CNT_W  = clog2_min1(TMO_CYC);
    localparam logic [CNT_W-1:0]   TC_VAL = CNT_W'(TMO_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc = (r_cnt == TC_VAL);

    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bublesort_stream_drv.sv
// Host-side initiator: streams a frame into the sorter, starts it, waits for done,
// then streams the sorted stage contents back out with a last flag.
module bublesort_stream_drv
    import bublesort_pkg::*;
#(
    parameter int unsigned N_BITS    = 8,
    parameter int unsigned K_NUMBERS = 49,
    parameter int unsigned TMO_CYC   = 4096
) (
    input logic                   clk,
    input logic                   rst,
    bublesort_stream_drv_if.slave bus
);
    localparam int unsigned      IDX_W    = clog2_min1(K_NUMBERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K_NUMBERS - 1);

    state_e                      r_state, w_state_d;
    logic [IDX_W-1:0]            r_idx, w_idx_d;
    logic [IDX_W-1:0]            r_rd_idx, w_rd_idx_d;
    logic                        r_armed, w_armed_d;
    logic                        r_tmo_err, w_tmo_err_d;
    logic                        r_start, w_start_d;
    logic                        r_abort, w_abort_d;
    logic [K_NUMBERS-1:0]        r_load, w_load_d;
    logic [K_NUMBERS*N_BITS-1:0] r_wdata, w_wdata_d;
    logic                        r_s_ready, r_m_valid, r_busy;
    logic                        w_s_hs, w_m_hs;
    logic                        w_cnt_clr, w_cnt_en, w_tc;
    logic [N_BITS-1:0]           w_m_data;

    assign w_s_hs = bus.s_valid_i & r_s_ready;
    assign w_m_hs = r_m_valid & bus.m_ready_i;

    bublesort_tmo_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    always_comb begin
        w_state_d   = r_state;
        w_idx_d     = r_idx;
        w_rd_idx_d  = r_rd_idx;
        w_armed_d   = r_armed;
        w_tmo_err_d = r_tmo_err;
        w_start_d   = 1'b0;
        w_abort_d   = 1'b0;
        w_load_d    = '0;
        w_wdata_d   = r_wdata;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;

        // Host abort beats any handshake; only an in-flight sort needs the sorter aborted
        if (bus.abort_i) begin
            w_state_d  = ST_LOAD;
            w_idx_d    = '0;
            w_rd_idx_d = '0;
            w_abort_d  = (r_state == ST_START) || (r_state == ST_WAIT);
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    if (w_s_hs) begin
                        w_load_d  = K_NUMBERS'(1) << r_idx;
                        w_wdata_d = {K_NUMBERS{bus.s_data_i}};
                        if (r_idx == LAST_IDX) begin
                            w_state_d = ST_START;
                            w_idx_d   = '0;
                        end else begin
                            w_idx_d = r_idx + IDX_W'(1);
                        end
                    end
                end
                ST_START: begin
                    w_state_d = ST_WAIT;
                    w_start_d = 1'b1;
                    w_armed_d = 1'b0;
                    w_cnt_clr = 1'b1;
                end
                ST_WAIT: begin
                    w_cnt_en  = 1'b1;
                    // A done still high from the previous frame must not end this wait
                    w_armed_d = r_armed | ~bus.done_i;
                    if (r_armed && bus.done_i) begin
                        w_state_d  = ST_DRAIN;
                        w_rd_idx_d = '0;
                    end else if (w_tc) begin
                        w_state_d   = ST_LOAD;
                        w_tmo_err_d = 1'b1;
                        w_abort_d   = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_m_hs) begin
                        if (r_rd_idx == LAST_IDX) begin
                            w_state_d  = ST_LOAD;
                            w_rd_idx_d = '0;
                        end else begin
                            w_rd_idx_d = r_rd_idx + IDX_W'(1);
                        end
                    end
                end
                default: w_state_d = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_LOAD;
            r_idx     <= '0;
            r_rd_idx  <= '0;
            r_armed   <= 1'b0;
            r_tmo_err <= 1'b0;
            r_start   <= 1'b0;
            r_abort   <= 1'b0;
            r_load    <= '0;
            r_wdata   <= '0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_idx     <= w_idx_d;
            r_rd_idx  <= w_rd_idx_d;
            r_armed   <= w_armed_d;
            r_tmo_err <= w_tmo_err_d;
            r_start   <= w_start_d;
            r_abort   <= w_abort_d;
            r_load    <= w_load_d;
            r_wdata   <= w_wdata_d;
            r_s_ready <= (w_state_d == ST_LOAD);
            r_m_valid <= (w_state_d == ST_DRAIN);
            r_busy    <= !((w_state_d == ST_LOAD) && (w_idx_d == '0));
        end
    end

    // Sorter is idle in DRAIN, so readdata_i is stable under the registered read index
    always_comb begin
        w_m_data = '0;
        for (int i = 0; i < K_NUMBERS; i++) begin
            if (r_rd_idx == IDX_W'(i)) begin
                w_m_data = bus.readdata_i[i*N_BITS +: N_BITS];
            end
        end
    end

    assign bus.s_ready_o   = r_s_ready;
    assign bus.m_valid_o   = r_m_valid;
    assign bus.m_data_o    = w_m_data;
    assign bus.m_last_o    = r_m_valid && (r_rd_idx == LAST_IDX);
    assign bus.busy_o      = r_busy;
    assign bus.tmo_err_o   = r_tmo_err;
    assign bus.load_o      = r_load;
    assign bus.writedata_o = r_wdata;
    assign bus.start_o     = r_start;
    assign bus.abort_o     = r_abort;

endmodule

// File: tb/tb_bublesort_stream_drv.sv
// Bench for bublesort_stream_drv with a behavioural sorter and an output scoreboard.
module tb_bublesort_stream_drv;
    localparam int unsigned NB       = 8;
    localparam int unsigned K        = 4;
    localparam int unsigned TMO      = 16;
    localparam int unsigned SORT_LAT = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bublesort_stream_drv_if #(.N_BITS(NB), .K_NUMBERS(K)) bus ();

    bublesort_stream_drv #(
        .N_BITS    (NB),
        .K_NUMBERS (K),
        .TMO_CYC   (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [K*NB-1:0] sort_pack(input logic [K*NB-1:0] v);
        logic [NB-1:0]   a [K];
        logic [NB-1:0]   t;
        logic [K*NB-1:0] r;
        for (int i = 0; i < K; i++) a[i] = v[i*NB +: NB];
        for (int i = 0; i < K - 1; i++) begin
            for (int j = 0; j < K - 1 - i; j++) begin
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
            end
        end
        for (int i = 0; i < K; i++) r[i*NB +: NB] = a[i];
        return r;
    endfunction

    // Behavioural sorter
    typedef enum logic [1:0] {MIdle, MStale, MSort} mst_e;
    mst_e            mst = MIdle;
    logic [K*NB-1:0] stg = '0;
    int              st_cnt = 0;
    int              lat_cnt = 0;
    bit              stuck0 = 1'b0;
    int              stale_hold = 0;

    assign bus.readdata_i = stg;

    always @(posedge clk) begin
        if (!rst) begin
            mst        <= MIdle;
            bus.done_i <= 1'b0;
        end else begin
            for (int i = 0; i < K; i++) begin
                if (bus.load_o[i]) stg[i*NB +: NB] <= bus.writedata_o[i*NB +: NB];
            end
            if (bus.abort_o) begin
                mst        <= MIdle;
                bus.done_i <= 1'b0;
            end else if (bus.start_o) begin
                if (stale_hold > 0) begin
                    mst    <= MStale;
                    st_cnt <= stale_hold;
                end else begin
                    mst        <= MSort;
                    bus.done_i <= 1'b0;
                    lat_cnt    <= SORT_LAT;
                end
            end else begin
                case (mst)
                    MStale: begin
                        if (st_cnt <= 1) begin
                            mst        <= MSort;
                            bus.done_i <= 1'b0;
                            lat_cnt    <= SORT_LAT;
                        end else begin
                            st_cnt <= st_cnt - 1;
                        end
                    end
                    MSort: begin
                        if (!stuck0) begin
                            if (lat_cnt <= 1) begin
                                stg        <= sort_pack(stg);
                                bus.done_i <= 1'b1;
                                mst        <= MIdle;
                            end else begin
                                lat_cnt <= lat_cnt - 1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Scoreboard: one entry per expected output word
    typedef struct packed {
        logic [NB-1:0] data;
        logic          last;
    } exp_t;
    exp_t exp_q[$];
    int   n_out = 0;
    int   n_start = 0;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (bus.start_o && bus.abort_o) check_val("start_abort_same_cycle", 1, 0);
            if (bus.start_o) n_start++;
            if (bus.m_valid_o) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out_word", 1, 0);
                end else begin
                    check_val("m_data", bus.m_data_o, exp_q[0].data);
                    check_val("m_last", bus.m_last_o, exp_q[0].last);
                    if (bus.m_ready_i && !bus.abort_i) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [NB-1:0] d, input int slot);
        int n = 0;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = d;
        while (!bus.s_ready_o && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check_val("s_ready_timeout", 0, 1);
        tick();
        bus.s_valid_i = 1'b0;
        check_val("load_onehot", bus.load_o, 64'(1) << slot);
        check_val("writedata", bus.writedata_o, {K{d}});
    endtask

    task automatic send_frame(input logic [K*NB-1:0] w, input bit expect_out);
        logic [K*NB-1:0] s;
        exp_t            e;
        s = sort_pack(w);
        if (expect_out) begin
            for (int i = 0; i < K; i++) begin
                e.data = s[i*NB +: NB];
                e.last = (i == K - 1);
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < K; i++) send_word(w[i*NB +: NB], i);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.m_valid_o) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) check_val("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_start();
        int n = 0;
        while (!bus.start_o && n < 50) begin
            tick();
            n++;
        end
        check_val("start_seen", bus.start_o, 1);
    endtask

    initial begin
        int s0, o0, n;
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        bus.m_ready_i = 1'b0;
        bus.abort_i   = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        check_val("rst_s_ready", bus.s_ready_o, 0);
        check_val("rst_m_valid", bus.m_valid_o, 0);
        check_val("rst_m_last", bus.m_last_o, 0);
        check_val("rst_load", bus.load_o, 0);
        check_val("rst_start", bus.start_o, 0);
        check_val("rst_abort", bus.abort_o, 0);
        check_val("rst_busy", bus.busy_o, 0);
        check_val("rst_tmo_err", bus.tmo_err_o, 0);
        check_val("rst_writedata", bus.writedata_o, 0);
        rst = 1'b1;
        tick();
        check_val("post_rst_s_ready", bus.s_ready_o, 1);

        // 1: basic frame 7,3,9,1
        bus.m_ready_i = 1'b1;
        s0 = n_start;
        o0 = n_out;
        send_frame({8'd1, 8'd9, 8'd3, 8'd7}, 1'b1);
        check_val("t1_busy_in_start", bus.busy_o, 1);
        check_val("t1_s_ready_low", bus.s_ready_o, 0);
        wait_drain();
        check_val("t1_start_pulses", n_start - s0, 1);
        check_val("t1_words_out", n_out - o0, K);

        // 2: output backpressure
        o0 = n_out;
        send_frame({8'd5, 8'd200, 8'd20, 8'd50}, 1'b1);
        n = 0;
        while ((exp_q.size() != 0 || bus.m_valid_o) && n < 500) begin
            bus.m_ready_i = ~bus.m_ready_i;
            tick();
            n++;
        end
        bus.m_ready_i = 1'b1;
        check_val("t2_words_out", n_out - o0, K);
        repeat (3) tick();
        check_val("t2_idle_after", bus.m_valid_o, 0);

        // 3: stale done held across start
        stale_hold = 6;
        send_frame({8'd1, 8'd9, 8'd3, 8'd7}, 1'b1);
        wait_start();
        n = 0;
        while (mst != MSort && n < 50) begin
            check_val("t3_no_drain_while_stale", bus.m_valid_o, 0);
            tick();
            n++;
        end
        wait_drain();
        stale_hold = 0;

        // 4: done stuck low -> timeout
        stuck0 = 1'b1;
        send_frame({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);
        wait_start();
        n = 0;
        while (!bus.abort_o && n < 100) begin
            tick();
            n++;
        end
        check_val("t4_abort_delay", n, TMO);
        check_val("t4_tmo_err", bus.tmo_err_o, 1);
        check_val("t4_s_ready", bus.s_ready_o, 1);
        check_val("t4_no_start", bus.start_o, 0);
        repeat (5) tick();
        check_val("t4_tmo_sticky", bus.tmo_err_o, 1);
        check_val("t4_idle_busy", bus.busy_o, 0);
        stuck0 = 1'b0;

        // 5: host abort on the 3rd handshake
        send_word(8'd11, 0);
        send_word(8'd22, 1);
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 8'd33;
        bus.abort_i   = 1'b1;
        tick();
        bus.abort_i   = 1'b0;
        bus.s_valid_i = 1'b0;
        check_val("t5_no_load", bus.load_o, 0);
        check_val("t5_no_abort_o", bus.abort_o, 0);
        check_val("t5_busy_idx0", bus.busy_o, 0);
        check_val("t5_s_ready", bus.s_ready_o, 1);
        send_frame({8'd2, 8'd8, 8'd4, 8'd6}, 1'b1);
        wait_drain();
        check_val("t5_tmo_still_set", bus.tmo_err_o, 1);

        // 6: reset mid-DRAIN at rd_idx==2
        bus.m_ready_i = 1'b0;
        send_frame({8'd10, 8'd25, 8'd5, 8'd15}, 1'b1);
        n = 0;
        while (!bus.m_valid_o && n < 200) begin
            tick();
            n++;
        end
        check_val("t6_drain_reached", bus.m_valid_o, 1);
        bus.m_ready_i = 1'b1;
        tick();
        tick();
        bus.m_ready_i = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_val("t6_m_valid", bus.m_valid_o, 0);
        check_val("t6_s_ready", bus.s_ready_o, 1);
        check_val("t6_busy", bus.busy_o, 0);
        check_val("t6_tmo_err", bus.tmo_err_o, 0);

        // Recovery frame after reset
        bus.m_ready_i = 1'b1;
        send_frame({8'd0, 8'd255, 8'd128, 8'd64}, 1'b1);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
